// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch-stage states, constants and helpers
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Primary opcodes shared with the decoder
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;

  // Imm16 word offset -> sign-extended byte displacement
  function automatic logic [31:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - imem, decoder and redirect signals of the fetch stage
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc_out, fetch_fault,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset, jump, jump_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc_out, fetch_fault,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset, jump, jump_target
  );
endinterface

// File: rtl/instruction_fetch_next_pc_calc.sv
// rtl/instruction_fetch_next_pc_calc.sv - combinational next-PC selection
module next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;

  assign pc4 = pc + 32'd4;

  // Jump beats branch; everything wraps modulo 2^32
  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc4 + branch_disp(branch_offset);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, imem fetch and decoder hand-off
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
)
(
  input  logic                 clk,
  input  logic                 reset,
  instruction_fetch_if.master  bus
);

  localparam logic MISALIGNED = (RESET_PC[1:0] != 2'b00);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         fault_q;
  logic [31:0]  tmo_cnt;
  logic [31:0]  next_pc;
  logic         req;
  logic         handshake;
  logic         timeout_hit;

  assign handshake   = valid_q && bus.instr_ready;
  assign timeout_hit = (TIMEOUT != 0) && ((tmo_cnt + 32'd1) == TIMEOUT);

  next_pc_calc u_next_pc (
    .pc            (pc),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .next_pc       (next_pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and request decode; ack wins over a same-cycle timeout
  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      ST_IDLE:  state_next = MISALIGNED ? ST_FAULT : ST_FETCH;
      ST_FETCH: begin
        req = 1'b1;
        if (bus.imem_ack)  state_next = ST_HOLD;
        else if (timeout_hit) state_next = ST_FAULT;
      end
      ST_HOLD:  if (handshake) state_next = ST_FETCH;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // PC, fetched word, valid flag, sticky fault and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (MISALIGNED) fault_q <= 1'b1;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            valid_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (timeout_hit) fault_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            pc      <= next_pc;
            valid_q <= 1'b0;
            tmo_cnt <= '0;
          end
        end
        default: begin
          fault_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.pc_out      = pc;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench for instruction_fetch and next_pc_calc
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch_if bus_a ();
  instruction_fetch_if bus_b ();
  instruction_fetch_if bus_c ();

  instruction_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  instruction_fetch #(.RESET_PC(32'h1000_0040), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  instruction_fetch #(.RESET_PC(32'h0000_0002), .TIMEOUT(16)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  logic [31:0] u_pc;
  logic        u_br;
  logic [15:0] u_off;
  logic        u_j;
  logic [25:0] u_jt;
  logic [31:0] u_next;

  next_pc_calc u_npc (
    .pc(u_pc), .branch_taken(u_br), .branch_offset(u_off),
    .jump(u_j), .jump_target(u_jt), .next_pc(u_next));

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic [15:0] off;
    logic        j;
    logic [25:0] jt;
    logic [31:0] exp;
  } npc_vec_t;

  npc_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_a.imem_ack = 0; bus_a.imem_rdata = 0; bus_a.instr_ready = 0;
    bus_a.branch_taken = 0; bus_a.branch_offset = 0; bus_a.jump = 0; bus_a.jump_target = 0;
    bus_b.imem_ack = 0; bus_b.imem_rdata = 0; bus_b.instr_ready = 0;
    bus_b.branch_taken = 0; bus_b.branch_offset = 0; bus_b.jump = 0; bus_b.jump_target = 0;
    bus_c.imem_ack = 0; bus_c.imem_rdata = 0; bus_c.instr_ready = 0;
    bus_c.branch_taken = 0; bus_c.branch_offset = 0; bus_c.jump = 0; bus_c.jump_target = 0;
  endtask

  // From FETCH: zero-wait ack, then one-cycle handshake with the given redirect
  task automatic fetch_hs(input logic [31:0] rdata, input logic br, input logic [15:0] off,
                          input logic j, input logic [25:0] jt);
    bus_a.imem_ack = 1; bus_a.imem_rdata = rdata; bus_a.instr_ready = 0;
    tick();
    bus_a.imem_ack = 0;
    check("hs_valid", bus_a.instr_valid, 1);
    check("hs_instr", bus_a.instruction, rdata);
    bus_a.instr_ready = 1; bus_a.branch_taken = br; bus_a.branch_offset = off;
    bus_a.jump = j; bus_a.jump_target = jt;
    tick();
    bus_a.instr_ready = 0; bus_a.branch_taken = 0; bus_a.jump = 0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 16'h0000, 1'b0, 26'h0,       32'h0000_0004};
    vecs[1] = '{32'h0000_0100, 1'b1, 16'hFFFE, 1'b0, 26'h0,       32'h0000_00FC};
    vecs[2] = '{32'h0000_0100, 1'b1, 16'h0003, 1'b0, 26'h0,       32'h0000_0110};
    vecs[3] = '{32'h1000_0040, 1'b1, 16'h1234, 1'b1, 26'h0000010, 32'h1000_0040};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 16'h0000, 1'b0, 26'h0,       32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFC, 1'b1, 16'h0001, 1'b0, 26'h0,       32'h0000_0004};
    vecs[6] = '{32'h0FFF_FFFC, 1'b0, 16'h0000, 1'b1, 26'h3FFFFFF, 32'h1FFF_FFFC};
    vecs[7] = '{32'h0000_0200, 1'b1, 16'h8000, 1'b0, 26'h0,       32'hFFFE_0204};
    vecs[8] = '{32'h0000_0040, 1'b0, 16'hFFFF, 1'b0, 26'h0,       32'h0000_0044};
    vecs[9] = '{32'h0000_0040, 1'b1, 16'h7FFF, 1'b0, 26'h0,       32'h0002_0040};

    for (int i = 0; i < 10; i++) begin
      u_pc = vecs[i].pc; u_br = vecs[i].br; u_off = vecs[i].off;
      u_j = vecs[i].j; u_jt = vecs[i].jt;
      #1;
      check($sformatf("npc[%0d]", i), u_next, vecs[i].exp);
    end

    clear_inputs();
    reset = 1;
    tick(); tick();
    check("rst_req", bus_a.imem_req, 0);
    check("rst_valid", bus_a.instr_valid, 0);
    check("rst_fault", bus_a.fetch_fault, 0);
    check("rst_pc", bus_a.pc_out, 32'h0);
    check("rst_instr", bus_a.instruction, 32'h0);
    reset = 0;
    check("idle_req", bus_a.imem_req, 0);

    // Zero-wait memory, decoder always ready
    tick();
    check("t1_req", bus_a.imem_req, 1);
    check("t1_addr", bus_a.imem_addr, 32'h0);
    bus_a.imem_ack = 1; bus_a.imem_rdata = 32'h2210AAAA; bus_a.instr_ready = 1;
    tick();
    bus_a.imem_ack = 0;
    check("t1_valid", bus_a.instr_valid, 1);
    check("t1_instr", bus_a.instruction, 32'h2210AAAA);
    check("t1_pc", bus_a.pc_out, 32'h0);
    tick();
    bus_a.instr_ready = 0;
    check("t1_req2", bus_a.imem_req, 1);
    check("t1_addr2", bus_a.imem_addr, 32'h4);

    // Three wait states, then five stalled HOLD cycles with a redirect that must be ignored
    for (int i = 0; i < 3; i++) begin
      check("t2_wait_req", bus_a.imem_req, 1);
      check("t2_wait_addr", bus_a.imem_addr, 32'h4);
      tick();
    end
    bus_a.imem_ack = 1; bus_a.imem_rdata = 32'h1234_5678;
    tick();
    bus_a.imem_ack = 0;
    bus_a.jump = 1; bus_a.jump_target = 26'h3FFFFFF; bus_a.branch_taken = 1; bus_a.branch_offset = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", bus_a.instr_valid, 1);
      check("t2_hold_instr", bus_a.instruction, 32'h1234_5678);
      check("t2_hold_pc", bus_a.pc_out, 32'h4);
      tick();
    end
    bus_a.jump = 0; bus_a.branch_taken = 0; bus_a.instr_ready = 1;
    tick();
    bus_a.instr_ready = 0;
    check("t2_next_addr", bus_a.imem_addr, 32'h8);
    check("t2_valid_clr", bus_a.instr_valid, 0);

    // Branches backward and forward from 0x100
    fetch_hs(32'h0800_0040, 0, 16'h0, 1, 26'h0000040);
    check("t3_jmp_addr", bus_a.imem_addr, 32'h100);
    fetch_hs(32'h1000_FFFE, 1, 16'hFFFE, 0, 26'h0);
    check("t3_br_back", bus_a.imem_addr, 32'hFC);
    fetch_hs(32'h0800_0040, 0, 16'h0, 1, 26'h0000040);
    check("t3_jmp_addr2", bus_a.imem_addr, 32'h100);
    fetch_hs(32'h1000_0003, 1, 16'h0003, 0, 26'h0);
    check("t3_br_fwd", bus_a.imem_addr, 32'h110);

    // Memory never acks
    for (int i = 0; i < 16; i++) begin
      check("t5_req", bus_a.imem_req, 1);
      check("t5_nofault", bus_a.fetch_fault, 0);
      tick();
    end
    check("t5_fault", bus_a.fetch_fault, 1);
    check("t5_req_off", bus_a.imem_req, 0);
    check("t5_valid", bus_a.instr_valid, 0);
    check("t5_pc_kept", bus_a.pc_out, 32'h110);
    tick(); tick(); tick();
    check("t5_sticky", bus_a.fetch_fault, 1);
    check("t5_req_off2", bus_a.imem_req, 0);
    reset = 1;
    tick();
    reset = 0;
    check("t5_rst_fault", bus_a.fetch_fault, 0);
    check("t5_rst_pc", bus_a.pc_out, 32'h0);
    tick();
    check("t5_restart_req", bus_a.imem_req, 1);
    check("t5_restart_addr", bus_a.imem_addr, 32'h0);

    // Reset mid-HOLD
    bus_a.imem_ack = 1; bus_a.imem_rdata = 32'hAAAA_0001;
    tick();
    bus_a.imem_ack = 0;
    check("t6_in_hold", bus_a.instr_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    check("t6_hold_valid", bus_a.instr_valid, 0);
    check("t6_hold_pc", bus_a.pc_out, 32'h0);
    check("t6_hold_req", bus_a.imem_req, 0);
    tick();
    check("t6_resume_req", bus_a.imem_req, 1);

    // Reset mid-FETCH with an ack in the reset cycle
    reset = 1; bus_a.imem_ack = 1; bus_a.imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 0; bus_a.imem_ack = 0;
    check("t6_ack_valid", bus_a.instr_valid, 0);
    check("t6_ack_instr", bus_a.instruction, 32'h0);
    check("t6_ack_req", bus_a.imem_req, 0);
    tick();
    check("t6_resume2_req", bus_a.imem_req, 1);
    check("t6_resume2_addr", bus_a.imem_addr, 32'h0);

    // Wrap from the top of the address space
    fetch_hs(32'h1000_FFFE, 1, 16'hFFFE, 0, 26'h0);
    check("t6_top_addr", bus_a.imem_addr, 32'hFFFF_FFFC);
    fetch_hs(32'h0, 0, 16'h0, 0, 26'h0);
    check("t6_wrap_addr", bus_a.imem_addr, 32'h0);
    check("t6_wrap_fault", bus_a.fetch_fault, 0);

    // Misaligned reset PC and disabled timeout / jump priority on second instance
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    check("c_fault", bus_c.fetch_fault, 1);
    check("c_req", bus_c.imem_req, 0);
    check("b_req", bus_b.imem_req, 1);
    check("b_addr", bus_b.imem_addr, 32'h1000_0040);
    for (int i = 0; i < 20; i++) tick();
    check("b_no_timeout", bus_b.fetch_fault, 0);
    check("b_still_req", bus_b.imem_req, 1);
    bus_b.imem_ack = 1; bus_b.imem_rdata = 32'h0800_0010;
    tick();
    bus_b.imem_ack = 0;
    check("b_valid", bus_b.instr_valid, 1);
    bus_b.jump = 1; bus_b.branch_taken = 1; bus_b.jump_target = 26'h3FFFFFF; bus_b.branch_offset = 16'h0040;
    tick(); tick();
    check("b_stall_valid", bus_b.instr_valid, 1);
    check("b_stall_pc", bus_b.pc_out, 32'h1000_0040);
    bus_b.instr_ready = 1; bus_b.jump_target = 26'h0000010; bus_b.branch_offset = 16'h0005;
    tick();
    bus_b.instr_ready = 0; bus_b.jump = 0; bus_b.branch_taken = 0;
    check("b_jump_wins", bus_b.imem_addr, 32'h1000_0040);
    check("b_req_after", bus_b.imem_req, 1);
    check("b_valid_clr", bus_b.instr_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the PC register and fetches from instruction memory over a req/ack handshake.
- Holds the fetched word stable for the decoder under a valid/ready handshake.
- Computes the next PC from sequential, branch or jump redirects, and flags fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
TIMEOUT, 16, max cycles waiting in FETCH for imem_ack before fault; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; high only in FETCH
imem_addr  out  32  byte address of fetch, equals pc
imem_ack  in  1  memory returns imem_rdata this cycle; ignored outside FETCH
imem_rdata  in  32  fetched instruction word
instruction  out  32  registered instruction to decoder
instr_valid  out  1  instruction/pc_out are valid
instr_ready  in  1  decoder accepts the instruction this cycle
pc_out  out  32  address of the instruction currently presented
branch_taken  in  1  redirect to the branch target; sampled on handshake only
branch_offset  in  16  Imm16 word offset, sign-extended
jump  in  1  redirect to the jump target; sampled on handshake only
jump_target  in  26  instruction[25:0] jump field
fetch_fault  out  1  sticky fault indication

Behaviour:
- States: IDLE, FETCH, HOLD, FAULT. State, pc, instruction, instr_valid and fetch_fault are registered.
- Reset (synchronous, any state, including mid-FETCH or mid-HOLD):
  - State IDLE, pc = RESET_PC, instruction = 32'h0 (NOP), instr_valid = 0, fetch_fault = 0, timeout counter = 0.
  - An ack arriving in the reset cycle is discarded.
- IDLE:
  - Always transitions to FETCH next cycle. imem_req = 0.
  - The first request is therefore visible 1 cycle after reset deasserts.
- FETCH:
  - imem_req = 1, imem_addr = pc, held stable until ack.
  - On imem_ack, an ack in the same cycle as the req is legal (zero-wait memory). Then:
    - instruction <= imem_rdata, pc_out = pc, instr_valid <= 1, go to HOLD.
  - Otherwise increment the timeout counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with no ack, go to FAULT.
  - The counter clears on entry to FETCH.
- HOLD:
  - instr_valid = 1. instruction and pc_out are stable until the handshake completes.
  - Handshake completes when instr_valid && instr_ready. In that cycle:
    - Sample the redirect inputs and compute next pc.
    - instr_valid <= 0, go to FETCH.
  - If instr_ready is low, stay in HOLD; redirect inputs are ignored.
  - Minimum throughput: 2 cycles per instruction with zero-wait memory.
- Next-PC rules (computed from pc, pc4 = pc + 4):
  - jump = 1 → {pc4[31:28], jump_target, 2'b00}. Jump has priority over branch_taken when both are high.
  - else branch_taken = 1 → pc4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}).
  - else → pc4.
  - All arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal and not a fault.
- Misalignment:
  - If RESET_PC[1:0] != 0, go to FAULT from IDLE.
  - By construction all redirects are word-aligned, so no other misalignment check is needed.
- FAULT:
  - fetch_fault = 1, imem_req = 0, instr_valid = 0.
  - Stays until reset. The last pc is retained on pc_out for debug.

Decomposition:
- Shared package/header fetch_defs holds:
  - state encodings (IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, FAULT = 2'd3)
  - NOP_INSTR = 32'h0
  - default RESET_PC
  - opcode constants also used by the decoder
- One combinational sub-module, next_pc_calc, with inputs pc, branch_taken, branch_offset, jump, jump_target and output next_pc. It can be unit-tested on its own.

Test Plan:
1. Reset, then zero-wait memory returning 32'h2210AAAA at address 0; instr_ready = 1 → imem_req high at cycle 1; instr_valid high at cycle 2 with instruction = 32'h2210AAAA and pc_out = 0; next imem_addr = 4.
2. Memory acks after 3 wait cycles; instr_ready held low 5 cycles → imem_addr stable during the wait; instruction and pc_out stable for all 5 HOLD cycles; pc advances by exactly 4 after the handshake.
3. pc = 32'h0000_0100, branch_taken = 1, branch_offset = 16'hFFFE on handshake → next fetch at 32'h0000_00FC. branch_offset = 16'h0003 → 32'h0000_0110.
4. pc = 32'h1000_0040, jump = 1 and branch_taken = 1, jump_target = 26'h0000010 → next fetch at 32'h1000_0040 (jump wins); a redirect asserted while instr_ready = 0 has no effect.
5. TIMEOUT = 16, memory never acks → fetch_fault = 1 after 16 FETCH cycles; imem_req = 0 thereafter; reset clears the fault and a fetch restarts at RESET_PC.
6. Reset asserted mid-HOLD and mid-FETCH with an ack in the same cycle → ack discarded; instr_valid = 0; pc = RESET_PC; fetch resumes 1 cycle after reset deasserts. Also pc = 32'hFFFF_FFFC sequential → wraps to 0 with no fault.
